uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame
// geometry and the divider clamp used when a frame starts.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;

    // Dividers below MIN_DIV leave no room for a mid-bit sample; clamp them.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        if (div < 16'(MIN_DIV)) begin
            return 16'(MIN_DIV);
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through head. A pop on a full
// FIFO frees the slot the same cycle, so a simultaneous push is accepted.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Reads of an empty FIFO show zero so the head never leaks stale bytes.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: input synchronizer, start/data/stop FSM with a
// per-frame latched divider, sticky error flags and a registered irq.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 rx,
    input  logic                 rx_en,
    input  logic [15:0]          clk_div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 irq
);

    logic                 rx_p0, rx_p1, rx_p2;
    logic                 start_edge;
    rx_state_t            state_q, state_n;
    logic [15:0]          cnt_q, cnt_n;
    logic [15:0]          div_q, div_n;
    logic [2:0]           bit_q, bit_n;
    logic [DATA_BITS-1:0] shift_q;
    logic                 shift_en, push, set_fe, set_ovr;
    logic                 fifo_full, fifo_empty;

    // rx_p1 is the synchronized line; rx_p2 holds its previous value.
    assign start_edge = rx_p2 & ~rx_p1;
    assign rx_busy    = (state_q != ST_IDLE);
    assign rx_valid   = ~fifo_empty;
    // A pop on a full FIFO makes room, so only a push without pop overruns.
    assign set_ovr    = push & fifo_full & ~rx_ready;

    // Synchronizer, FSM registers, sticky flags and irq; line flops idle high.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_p0     <= 1'b1;
            rx_p1     <= 1'b1;
            rx_p2     <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            div_q     <= 16'(MIN_DIV);
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            rx_p0     <= rx;
            rx_p1     <= rx_p0;
            rx_p2     <= rx_p1;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            div_q     <= div_n;
            frame_err <= set_fe | (frame_err & ~err_clr);
            overrun   <= set_ovr | (overrun & ~err_clr);
            irq       <= rx_valid | frame_err | overrun;
        end
    end

    // Data shift register, LSB arrives first and ends in bit 0.
    always_ff @(posedge wb_clk_i) begin
        if (shift_en) shift_q <= {rx_p1, shift_q[DATA_BITS-1:1]};
    end

    // Next-state logic: mid-bit sampling driven by the latched divider.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        bit_n    = bit_q;
        div_n    = div_q;
        shift_en = 1'b0;
        push     = 1'b0;
        set_fe   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_en && start_edge) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                    bit_n   = '0;
                    div_n   = clamp_div(clk_div);
                end
            end
            ST_START: begin
                if (cnt_q == (div_q >> 1)) begin
                    cnt_n   = '0;
                    state_n = rx_p1 ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == div_q - 16'd1) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == div_q - 16'd1) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (rx_p1) push   = 1'b1;
                    else       set_fe = 1'b1;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Losing the enable mid-frame abandons the frame silently.
        if (state_q != ST_IDLE && !rx_en) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            bit_n    = '0;
            shift_en = 1'b0;
            push     = 1'b0;
            set_fe   = 1'b0;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .push      (push),
        .push_data (shift_q),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed table, multi-cycle corner sequences and
// randomized frames checked against a queue-based receiver model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        rx       = 1'b1;
    logic        rx_en    = 1'b1;
    logic [15:0] clk_div  = 16'd16;
    logic        rx_ready = 1'b0;
    logic        err_clr  = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_busy, frame_err, overrun, irq;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .rx        (rx),
        .rx_en     (rx_en),
        .clk_div   (clk_div),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // mode 0: plain; 1: one-cycle rx_ready on the stop-sample edge;
    // 2: one-cycle err_clr on the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div,
                              input int gap, input int mode);
        int d;
        int h;
        d = (div < 4) ? 4 : div;
        h = d / 2;
        clk_div = 16'(div);
        @(posedge wb_clk_i); #1 rx = 1'b0;
        repeat (d) @(posedge wb_clk_i);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (d) @(posedge wb_clk_i);
            #1;
        end
        rx = stop;
        if (mode != 0) begin
            repeat (3 + h) @(posedge wb_clk_i);
            #1;
            if (mode == 1) rx_ready = 1'b1;
            else           err_clr  = 1'b1;
            @(posedge wb_clk_i); #1;
            rx_ready = 1'b0;
            err_clr  = 1'b0;
            repeat (d - 4 - h) @(posedge wb_clk_i);
            #1;
        end else begin
            repeat (d) @(posedge wb_clk_i);
            #1;
        end
        rx = 1'b1;
        repeat (gap) @(posedge wb_clk_i);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge wb_clk_i);
        check({name, " valid"}, 32'(rx_valid), 1);
        check({name, " data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(posedge wb_clk_i); #1 rx_ready = 1'b0;
    endtask

    task automatic clear_errors();
        @(posedge wb_clk_i); #1 err_clr = 1'b1;
        @(posedge wb_clk_i); #1 err_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         div;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[6];

    logic [7:0] mq[$];
    logic       m_fe, m_ovr;
    logic [7:0] rb;
    logic       rstop;
    int         rdiv, rgap, nfr, seen;

    initial begin
        tbl[0] = '{8'h3D, 1'b1, 16, 1'b1, 8'h3D, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 16, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h00, 1'b1, 4,  1'b1, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 2,  1'b1, 8'hFF, 1'b0};
        tbl[4] = '{8'h81, 1'b1, 7,  1'b1, 8'h81, 1'b0};
        tbl[5] = '{8'h5A, 1'b1, 0,  1'b1, 8'h5A, 1'b0};

        // Asynchronous reset before any clock edge.
        #2 wb_rst_i = 1'b1;
        #2;
        check("rst rx_valid", 32'(rx_valid), 0);
        check("rst rx_data", 32'(rx_data), 0);
        check("rst rx_busy", 32'(rx_busy), 0);
        check("rst frame_err", 32'(frame_err), 0);
        check("rst overrun", 32'(overrun), 0);
        check("rst irq", 32'(irq), 0);
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        repeat (5) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("post-rst idle", 32'(rx_busy), 0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].b, tbl[i].stop, tbl[i].div, 3, 0);
            @(negedge wb_clk_i);
            check($sformatf("tbl%0d valid", i), 32'(rx_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d frame_err", i), 32'(frame_err), 32'(tbl[i].exp_fe));
            if (tbl[i].exp_valid) pop_expect($sformatf("tbl%0d", i), tbl[i].exp_data);
            clear_errors();
            @(negedge wb_clk_i);
            check($sformatf("tbl%0d drained", i), 32'(rx_valid), 0);
        end

        // 0x3D at 16 cycles per bit, irq behaviour around a single pop.
        send_frame(8'h3D, 1'b1, 16, 0, 0);
        @(negedge wb_clk_i);
        check("3D valid", 32'(rx_valid), 1);
        check("3D data", 32'(rx_data), 'h3D);
        check("3D irq", 32'(irq), 1);
        rx_ready = 1'b1;
        @(posedge wb_clk_i); #1 rx_ready = 1'b0;
        @(negedge wb_clk_i);
        check("3D popped", 32'(rx_valid), 0);
        @(negedge wb_clk_i);
        check("3D irq low", 32'(irq), 0);

        // Five back-to-back frames into a four-entry FIFO.
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 16, 0, 0);
        @(negedge wb_clk_i);
        check("ovr flag", 32'(overrun), 1);
        check("ovr irq", 32'(irq), 1);
        for (int v = 1; v <= 4; v++) pop_expect($sformatf("ovr pop%0d", v), 8'(v));
        @(negedge wb_clk_i);
        check("ovr fifth empty", 32'(rx_valid), 0);
        clear_errors();
        @(negedge wb_clk_i);
        check("ovr cleared", 32'(overrun), 0);

        // Bad stop bit.
        send_frame(8'hA5, 1'b0, 16, 3, 0);
        @(negedge wb_clk_i);
        check("fe flag", 32'(frame_err), 1);
        check("fe no push", 32'(rx_valid), 0);
        clear_errors();
        @(negedge wb_clk_i);
        check("fe cleared", 32'(frame_err), 0);
        @(negedge wb_clk_i);
        check("fe irq low", 32'(irq), 0);

        // err_clr coinciding with the frame error: set wins.
        send_frame(8'hC3, 1'b0, 16, 3, 2);
        @(negedge wb_clk_i);
        check("fe set beats clr", 32'(frame_err), 1);
        clear_errors();

        // Four-cycle glitch at 16 cycles per bit.
        clk_div = 16'd16;
        @(posedge wb_clk_i); #1 rx = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        #1 rx = 1'b1;
        @(negedge wb_clk_i);
        check("glitch busy", 32'(rx_busy), 1);
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge wb_clk_i);
            if (!rx_busy) begin
                seen = 1;
                break;
            end
        end
        check("glitch busy clears", 32'(seen), 1);
        repeat (20) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("glitch no push", 32'(rx_valid), 0);
        check("glitch no errors", 32'({frame_err, overrun}), 0);

        // Push and pop on the same edge while full.
        send_frame(8'h11, 1'b1, 16, 0, 0);
        send_frame(8'h22, 1'b1, 16, 0, 0);
        send_frame(8'h33, 1'b1, 16, 0, 0);
        send_frame(8'h44, 1'b1, 16, 0, 0);
        send_frame(8'h77, 1'b1, 16, 2, 1);
        @(negedge wb_clk_i);
        check("full pushpop overrun", 32'(overrun), 0);
        pop_expect("fpp 22", 8'h22);
        pop_expect("fpp 33", 8'h33);
        pop_expect("fpp 44", 8'h44);
        pop_expect("fpp 77", 8'h77);
        @(negedge wb_clk_i);
        check("fpp empty", 32'(rx_valid), 0);

        // rx_en dropped during data bit 3; a queued byte must survive.
        send_frame(8'h99, 1'b1, 16, 3, 0);
        @(posedge wb_clk_i); #1 rx = 1'b0;
        repeat (16) @(posedge wb_clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h5C >> i);
            repeat (16) @(posedge wb_clk_i);
            #1;
        end
        rx = 1'b1;
        repeat (8) @(posedge wb_clk_i);
        #1 rx_en = 1'b0;
        @(negedge wb_clk_i);
        check("abort busy before", 32'(rx_busy), 1);
        @(negedge wb_clk_i);
        check("abort busy after", 32'(rx_busy), 0);
        repeat (120) @(posedge wb_clk_i);
        #1 rx_en = 1'b1;
        @(negedge wb_clk_i);
        check("abort no errors", 32'({frame_err, overrun}), 0);
        pop_expect("abort kept", 8'h99);
        @(negedge wb_clk_i);
        check("abort no push", 32'(rx_valid), 0);

        // Reset in the middle of a frame with data and an error pending.
        send_frame(8'h42, 1'b1, 16, 3, 0);
        send_frame(8'hA5, 1'b0, 16, 3, 0);
        @(negedge wb_clk_i);
        check("pre-rst irq", 32'(irq), 1);
        @(posedge wb_clk_i); #1 rx = 1'b0;
        repeat (40) @(posedge wb_clk_i);
        #1 rx = 1'b1;
        #1 wb_rst_i = 1'b1;
        #1;
        check("midrst rx_valid", 32'(rx_valid), 0);
        check("midrst rx_data", 32'(rx_data), 0);
        check("midrst rx_busy", 32'(rx_busy), 0);
        check("midrst frame_err", 32'(frame_err), 0);
        check("midrst irq", 32'(irq), 0);
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        repeat (20) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("midrst quiet", 32'(rx_busy), 0);
        send_frame(8'h0F, 1'b1, 16, 3, 0);
        pop_expect("midrst 0F", 8'h0F);
        @(negedge wb_clk_i);
        check("midrst empty", 32'(rx_valid), 0);

        // Randomized frames against a queue model of the receiver.
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        for (int r = 0; r < 8; r++) begin
            nfr = int'($urandom_range(1, 6));
            for (int f = 0; f < nfr; f++) begin
                rb    = 8'($urandom);
                rstop = ($urandom_range(0, 7) != 0);
                rdiv  = int'($urandom_range(0, 20));
                rgap  = int'($urandom_range(2, 8));
                if (!rstop)              m_fe  = 1'b1;
                else if (mq.size() >= DEPTH) m_ovr = 1'b1;
                else                     mq.push_back(rb);
                send_frame(rb, rstop, rdiv, rgap, 0);
            end
            @(negedge wb_clk_i);
            check($sformatf("rnd%0d frame_err", r), 32'(frame_err), 32'(m_fe));
            check($sformatf("rnd%0d overrun", r), 32'(overrun), 32'(m_ovr));
            check($sformatf("rnd%0d irq", r), 32'(irq), 32'((mq.size() > 0) || m_fe || m_ovr));
            while (mq.size() > 0) pop_expect($sformatf("rnd%0d pop", r), mq.pop_front());
            @(negedge wb_clk_i);
            check($sformatf("rnd%0d drained", r), 32'(rx_valid), 0);
            clear_errors();
            m_fe  = 1'b0;
            m_ovr = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
